// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the AXI master port between the I-cache refill FSM and the data-side requester
// Define ARB_ROUND_ROBIN_EN to alternate winners on simultaneous requests instead of fixed data-first priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_i_req_rd,
  input  logic [ADDR_WIDTH-1:0] i_i_addr,
  input  logic                  i_d_req_rd,
  input  logic                  i_d_req_wr,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic                  i_r_valid,
  input  logic                  i_r_last,
  input  logic                  i_b_resp,
  output logic                  o_start_read,
  output logic                  o_start_write,
  output logic [ADDR_WIDTH-1:0] o_axi_addr,
  output logic                  o_grant_i,
  output logic                  o_grant_d,
  output logic [BEAT_WIDTH-1:0] o_beat_idx,
  output logic                  o_i_done,
  output logic                  o_d_done,
  output logic                  o_timeout
);

  typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT, WR_WAIT, DONE} state_t;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                state, state_nxt;
  logic                  win_d;
  logic                  is_wr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BEAT_WIDTH-1:0] beat_q;
  logic                  timeout_q;
  logic                  wd_hit;
  logic                  d_any, req_any, pick_d, pick_wr;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic                  in_wait;

  assign d_any   = i_d_req_rd | i_d_req_wr;
  assign req_any = d_any | i_i_req_rd;
  assign in_wait = (state == RD_WAIT) || (state == WR_WAIT);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  // On a tie the side that lost last time wins; a lone requester always wins.
  assign pick_d = d_any & (~i_i_req_rd | ~last_d);
`else
  assign pick_d = d_any;
`endif

  assign pick_wr   = pick_d & i_d_req_wr;
  assign pick_addr = pick_d ? i_d_addr : i_i_addr;

  generate
    if (TIMEOUT != 0) begin : g_wd
      logic [WD_W-1:0] wd_cnt;
      always_ff @(posedge clk) begin
        if (!arst) begin
          wd_cnt <= '0;
        end else if (state == ISSUE) begin
          wd_cnt <= '0;
        end else if (in_wait) begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end
      assign wd_hit = in_wait && (wd_cnt == WD_LAST);
    end else begin : g_no_wd
      assign wd_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = is_wr ? WR_WAIT : RD_WAIT;
      RD_WAIT: if ((i_r_valid & i_r_last) | wd_hit) state_nxt = DONE;
      WR_WAIT: if (i_b_resp | wd_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      state     <= IDLE;
      win_d     <= 1'b0;
      is_wr     <= 1'b0;
      addr_q    <= '0;
      beat_q    <= '0;
      timeout_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_any) begin
        win_d  <= pick_d;
        is_wr  <= pick_wr;
        addr_q <= pick_addr;
`ifdef ARB_ROUND_ROBIN_EN
        last_d <= pick_d;
`endif
      end
      // Index is presented alongside i_r_valid, so it advances after each accepted beat.
      if (state == ISSUE) begin
        beat_q <= '0;
      end else if (state == RD_WAIT && i_r_valid) begin
        beat_q <= beat_q + BEAT_WIDTH'(1);
      end
      if (wd_hit) timeout_q <= 1'b1;
    end
  end

  assign o_start_read  = (state == ISSUE) & ~is_wr;
  assign o_start_write = (state == ISSUE) & is_wr;
  assign o_axi_addr    = addr_q;
  assign o_grant_i     = (state != IDLE) & ~win_d;
  assign o_grant_d     = (state != IDLE) & win_d;
  assign o_beat_idx    = beat_q;
  assign o_i_done      = (state == DONE) & ~win_d;
  assign o_d_done      = (state == DONE) & win_d;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst;
  logic        i_i_req_rd, i_d_req_rd, i_d_req_wr;
  logic [31:0] i_i_addr, i_d_addr;
  logic        i_r_valid, i_r_last, i_b_resp;
  logic        o_start_read, o_start_write, o_grant_i, o_grant_d;
  logic        o_i_done, o_d_done, o_timeout;
  logic [31:0] o_axi_addr;
  logic [3:0]  o_beat_idx;

  logic        w_d_req_rd, w_d_req_wr, w_r_valid, w_r_last, w_b_resp;
  logic [31:0] w_d_addr;
  logic        w_start_read, w_start_write, w_grant_i, w_grant_d;
  logic        w_i_done, w_d_done, w_timeout;
  logic [31:0] w_axi_addr;
  logic [3:0]  w_beat_idx;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .BEAT_WIDTH(4), .TIMEOUT(1023)) dut (
    .clk(clk), .arst(arst),
    .i_i_req_rd(i_i_req_rd), .i_i_addr(i_i_addr),
    .i_d_req_rd(i_d_req_rd), .i_d_req_wr(i_d_req_wr), .i_d_addr(i_d_addr),
    .i_r_valid(i_r_valid), .i_r_last(i_r_last), .i_b_resp(i_b_resp),
    .o_start_read(o_start_read), .o_start_write(o_start_write),
    .o_axi_addr(o_axi_addr), .o_grant_i(o_grant_i), .o_grant_d(o_grant_d),
    .o_beat_idx(o_beat_idx), .o_i_done(o_i_done), .o_d_done(o_d_done),
    .o_timeout(o_timeout)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .BEAT_WIDTH(4), .TIMEOUT(8)) dut_wd (
    .clk(clk), .arst(arst),
    .i_i_req_rd(1'b0), .i_i_addr(32'h0),
    .i_d_req_rd(w_d_req_rd), .i_d_req_wr(w_d_req_wr), .i_d_addr(w_d_addr),
    .i_r_valid(w_r_valid), .i_r_last(w_r_last), .i_b_resp(w_b_resp),
    .o_start_read(w_start_read), .o_start_write(w_start_write),
    .o_axi_addr(w_axi_addr), .o_grant_i(w_grant_i), .o_grant_d(w_grant_d),
    .o_beat_idx(w_beat_idx), .o_i_done(w_i_done), .o_d_done(w_d_done),
    .o_timeout(w_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return 32'({o_start_read, o_start_write, o_grant_i, o_grant_d, o_i_done, o_d_done, o_timeout});
  endfunction

  initial begin
    arst = 1'b0;
    i_i_req_rd = 0; i_d_req_rd = 0; i_d_req_wr = 0;
    i_i_addr = 0; i_d_addr = 0;
    i_r_valid = 0; i_r_last = 0; i_b_resp = 0;
    w_d_req_rd = 0; w_d_req_wr = 0; w_d_addr = 0;
    w_r_valid = 0; w_r_last = 0; w_b_resp = 0;
    tick(); tick();
    check("reset_flags", flags(), 32'h0);
    check("reset_addr", o_axi_addr, 32'h0);
    check("reset_beat", 32'(o_beat_idx), 32'h0);
    arst = 1'b1;
    tick();

    // I-read of four beats
    i_i_req_rd = 1; i_i_addr = 32'h8000_0040;
    check("i_idle_no_start", 32'(o_start_read), 0);
    tick();
    check("i_start_read", 32'(o_start_read), 1);
    check("i_start_write", 32'(o_start_write), 0);
    check("i_addr", o_axi_addr, 32'h8000_0040);
    check("i_grant_i", 32'(o_grant_i), 1);
    check("i_grant_d", 32'(o_grant_d), 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      i_r_valid = 1; i_r_last = (b == 3);
      check("i_beat_idx", 32'(o_beat_idx), 32'(b));
      check("i_no_early_done", 32'(o_i_done), 0);
      tick();
    end
    i_r_valid = 0; i_r_last = 0;
    check("i_done", 32'(o_i_done), 1);
    check("i_no_d_done", 32'(o_d_done), 0);
    i_i_req_rd = 0;
    tick();
    check("i_idle_after", 32'({o_grant_i, o_i_done}), 0);

    // simultaneous D-write and I-read: data first, then I back-to-back
    i_d_req_wr = 1; i_d_addr = 32'h1000;
    i_i_req_rd = 1; i_i_addr = 32'h2000;
    tick();
    check("dw_start_write", 32'(o_start_write), 1);
    check("dw_start_read", 32'(o_start_read), 0);
    check("dw_addr", o_axi_addr, 32'h1000);
    check("dw_grant_d", 32'(o_grant_d), 1);
    i_d_addr = 32'hDEAD;
    tick(); tick();
    check("dw_wait_no_done", 32'(o_d_done), 0);
    check("dw_addr_held", o_axi_addr, 32'h1000);
    i_b_resp = 1;
    tick();
    i_b_resp = 0;
    check("dw_d_done", 32'(o_d_done), 1);
    check("dw_no_i_done", 32'(o_i_done), 0);
    i_d_req_wr = 0;
    tick();
    check("dw_idle_grants", 32'({o_grant_i, o_grant_d}), 0);
    tick();
    check("i2_start_read", 32'(o_start_read), 1);
    check("i2_addr", o_axi_addr, 32'h2000);
    check("i2_grant_i", 32'(o_grant_i), 1);
    tick();
    i_r_valid = 1; i_r_last = 1;
    tick();
    i_r_valid = 0; i_r_last = 0;
    check("i2_done", 32'(o_i_done), 1);
    i_i_req_rd = 0;
    tick();

    // continuous I and D requests for four transactions
    i_i_req_rd = 1; i_i_addr = 32'h2000;
    i_d_req_rd = 1; i_d_addr = 32'h3000;
    for (int t = 0; t < 4; t++) begin
      logic exp_d;
      exp_d = RR ? (t % 2 == 0) : 1'b1;
      tick();
      check("arb_grant_d", 32'(o_grant_d), 32'(exp_d));
      check("arb_addr", o_axi_addr, exp_d ? 32'h3000 : 32'h2000);
      tick();
      i_r_valid = 1; i_r_last = 1;
      tick();
      i_r_valid = 0; i_r_last = 0;
      check("arb_done", 32'({o_i_done, o_d_done}), exp_d ? 32'h1 : 32'h2);
      if (t == 3) begin
        i_i_req_rd = 0; i_d_req_rd = 0;
      end
      tick();
    end

    // read with valid gaps on cycles 3,5,6,9 (request seen at cycle 0)
    i_i_req_rd = 1; i_i_addr = 32'h4000;
    tick(); tick();
    begin
      int seen;
      seen = 0;
      for (int c = 2; c <= 9; c++) begin
        i_r_valid = (c == 3) || (c == 5) || (c == 6) || (c == 9);
        i_r_last  = (c == 9);
        check("gap_beat_idx", 32'(o_beat_idx), 32'(seen));
        if (i_r_valid) seen++;
        tick();
      end
    end
    i_r_valid = 0; i_r_last = 0;
    check("gap_done", 32'(o_i_done), 1);
    i_i_req_rd = 0;
    tick();

    // watchdog on the TIMEOUT=8 instance
    w_d_req_rd = 1; w_d_addr = 32'h5000;
    tick();
    check("wd_start_read", 32'(w_start_read), 1);
    tick();
    for (int k = 1; k <= 8; k++) begin
      check("wd_no_early_done", 32'({w_d_done, w_timeout}), 0);
      tick();
    end
    check("wd_done", 32'(w_d_done), 1);
    check("wd_timeout", 32'(w_timeout), 1);
    w_d_req_rd = 0;
    tick();
    w_d_req_wr = 1;
    tick();
    check("wd2_start_write", 32'(w_start_write), 1);
    tick();
    w_b_resp = 1;
    tick();
    w_b_resp = 0;
    check("wd2_done", 32'(w_d_done), 1);
    check("wd2_timeout_sticky", 32'(w_timeout), 1);
    w_d_req_wr = 0;
    tick();
    check("wd_idle_timeout_sticky", 32'(w_timeout), 1);
    check("main_no_timeout", 32'(o_timeout), 0);

    // reset during beat 2, then the held request restarts
    i_i_req_rd = 1; i_i_addr = 32'h6000;
    tick(); tick();
    i_r_valid = 1;
    tick(); tick();
    check("rst_beat2", 32'(o_beat_idx), 2);
    arst = 0;
    tick();
    arst = 1; i_r_valid = 0;
    check("rst_flags", flags(), 32'h0);
    check("rst_addr", o_axi_addr, 32'h0);
    check("rst_beat", 32'(o_beat_idx), 32'h0);
    tick();
    check("rst_restart_read", 32'(o_start_read), 1);
    check("rst_restart_addr", o_axi_addr, 32'h6000);
    tick();
    i_r_valid = 1; i_r_last = 1;
    tick();
    i_r_valid = 0; i_r_last = 0;
    check("rst_restart_done", 32'(o_i_done), 1);
    i_i_req_rd = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
